mp_serial_adder: RTL and testbench

- Multi-precision sequential adder/subtractor that processes W-bit operands 16 bits per cycle.
- Feeds and consumes one instance of the team's 16-bit hybrid Brent-Kung/Kogge-Stone prefix adder core, which takes a, b and cin and returns sum and cout.
- Carry is registered between chunks, so wide adds reuse the single 16-bit core instead of needing a wide prefix tree.
- Sits between operand-producing datapath logic (valid/ready source) and result consumers (valid/ready sink).

---
 rtl/mp_serial_adder_pkg.sv | 20 ++
 rtl/mp_serial_adder_core.sv | 82 ++++++++
 rtl/mp_serial_adder.sv | 135 +++++++++++++
 tb/tb_mp_serial_adder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_serial_adder_pkg.sv
// Shared types and sizing helpers for the multi-precision serial adder.
package mp_serial_adder_pkg;

    localparam int unsigned CHUNK = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned num_chunks(input int unsigned w);
        return w / CHUNK;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mp_serial_adder_core.sv
// 16-bit hybrid prefix adder: Brent-Kung pair reduction, Kogge-Stone on the
// 8 pair groups, then a final Brent-Kung fix-up of the even bit positions.
module mp_serial_adder_core (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout
);

    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_g0;
    logic [7:0]  w_pg;
    logic [7:1]  w_pp;
    logic [7:0]  w_g1;
    logic [7:2]  w_p1;
    logic [7:0]  w_g2;
    logic [7:4]  w_p2;
    logic [7:0]  w_g3;
    logic [15:0] w_gc;

    assign w_g  = i_a & i_b;
    assign w_p  = i_a ^ i_b;
    // Carry-in folded into bit 0 so every prefix is a complete carry.
    assign w_g0 = {w_g[15:1], w_g[0] | (w_p[0] & i_cin)};

    always_comb begin
        w_pg = '0;
        w_pp = '0;
        for (int j = 0; j < 8; j++) begin
            w_pg[j] = w_g0[2*j+1] | (w_p[2*j+1] & w_g0[2*j]);
        end
        for (int j = 1; j < 8; j++) begin
            w_pp[j] = w_p[2*j+1] & w_p[2*j];
        end
    end

    always_comb begin
        w_g1 = w_pg;
        w_p1 = '0;
        for (int j = 1; j < 8; j++) begin
            w_g1[j] = w_pg[j] | (w_pp[j] & w_pg[j-1]);
        end
        for (int j = 2; j < 8; j++) begin
            w_p1[j] = w_pp[j] & w_pp[j-1];
        end
    end

    always_comb begin
        w_g2 = w_g1;
        w_p2 = '0;
        for (int j = 2; j < 8; j++) begin
            w_g2[j] = w_g1[j] | (w_p1[j] & w_g1[j-2]);
        end
        for (int j = 4; j < 8; j++) begin
            w_p2[j] = w_p1[j] & w_p1[j-2];
        end
    end

    always_comb begin
        w_g3 = w_g2;
        for (int j = 4; j < 8; j++) begin
            w_g3[j] = w_g2[j] | (w_p2[j] & w_g2[j-4]);
        end
    end

    always_comb begin
        w_gc    = '0;
        w_gc[0] = w_g0[0];
        for (int j = 0; j < 8; j++) begin
            w_gc[2*j+1] = w_g3[j];
        end
        for (int j = 1; j < 8; j++) begin
            w_gc[2*j] = w_g0[2*j] | (w_p[2*j] & w_g3[j-1]);
        end
    end

    assign o_sum  = w_p ^ {w_gc[14:0], i_cin};
    assign o_cout = w_gc[15];

endmodule

// File: rtl/mp_serial_adder.sv
// Multi-precision adder/subtractor: W-bit operands pushed through one 16-bit
// prefix core a chunk per cycle, with the carry held in a register.
module mp_serial_adder
    import mp_serial_adder_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf,
    output logic         out_zero,
    output logic         busy
);

    localparam int unsigned N  = num_chunks(W);
    localparam int unsigned KW = cnt_width(N);

    if ((W < CHUNK) || ((W % CHUNK) != 0)) begin : g_bad_width
        $error("mp_serial_adder: W must be a multiple of 16 and at least 16");
    end

    state_t          r_state;
    logic [KW-1:0]   r_k;
    logic            r_carry;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_core_sum;
    logic             w_core_cout;
    logic [W-1:0]     w_sum_next;
    logic             w_last;
    logic             w_top_carry;

    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (r_k == KW'(i)) begin
                w_a_chunk = r_a[i*CHUNK +: CHUNK];
                w_b_chunk = r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    mp_serial_adder_core u_core (
        .i_a    (w_a_chunk),
        .i_b    (w_b_chunk),
        .i_cin  (r_carry),
        .o_sum  (w_core_sum),
        .o_cout (w_core_cout)
    );

    // Result with the current chunk merged in, so out_zero sees the final value.
    always_comb begin
        w_sum_next = r_sum;
        for (int i = 0; i < N; i++) begin
            if (r_k == KW'(i)) begin
                w_sum_next[i*CHUNK +: CHUNK] = w_core_sum;
            end
        end
    end

    assign w_last      = (r_k == KW'(N - 1));
    assign w_top_carry = w_core_sum[CHUNK-1] ^ w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1];
    assign out_sum     = r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_carry   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= in_a;
                        r_b      <= in_sub ? ~in_b : in_b;
                        r_carry  <= in_sub ? 1'b1 : in_cin;
                        r_k      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_core_cout;
                    r_k     <= r_k + KW'(1);
                    if (w_last) begin
                        r_k       <= '0;
                        out_cout  <= w_core_cout;
                        out_ovf   <= w_top_carry ^ w_core_cout;
                        out_zero  <= (w_sum_next == '0);
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_serial_adder.sv
// Bench for mp_serial_adder (W=64): vector table plus scoreboard, with
// backpressure and mid-transaction reset sequences.
module tb_mp_serial_adder;

    localparam int N = 4;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;
    logic        busy;

    int   n_vec;
    int   n_miss;
    int   cyc;
    int   acc_cyc;
    logic prev_ov;
    vec_t sb[$];
    vec_t tbl[8];
    vec_t mon_e;

    mp_serial_adder #(.W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, required finish");
        $fatal(1, "watchdog timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic vec_t tv(input logic [63:0] a, input logic [63:0] b, input logic cin,
                                input logic sub, input logic [63:0] sum, input logic cout,
                                input logic ovf, input logic zero);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.sum = sum; v.cout = cout; v.ovf = ovf; v.zero = zero;
        return v;
    endfunction

    // Reference model: one wide add on 65 bits.
    function automatic vec_t mk(input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic sub);
        logic [63:0] bb;
        logic [64:0] s;
        bb = sub ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + 65'(sub ? 1'b1 : cin);
        return tv(a, b, cin, sub, s[63:0], s[64],
                  (a[63] == bb[63]) && (s[63] != a[63]), s[63:0] == 64'd0);
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input vec_t v);
        int t;
        t        = 0;
        in_a     = v.a;
        in_b     = v.b;
        in_cin   = v.cin;
        in_sub   = v.sub;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 50);
        chk("accept_wait", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        sb.push_back(v);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (out_valid && !prev_ov) begin
            chk("latency", 64'(cyc - acc_cyc), 64'(N));
        end
        prev_ov <= out_valid;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_result: got sum %h, required no result", out_sum);
            end else begin
                mon_e = sb.pop_front();
                chk("sum",  out_sum, mon_e.sum);
                chk("cout", 64'(out_cout), 64'(mon_e.cout));
                chk("ovf",  64'(out_ovf),  64'(mon_e.ovf));
                chk("zero", 64'(out_zero), 64'(mon_e.zero));
            end
        end
    end

    initial begin
        int   prev_acc;
        int   rel;
        int   t;
        vec_t vx;
        vec_t vy;

        n_vec     = 0;
        n_miss    = 0;
        acc_cyc   = 0;
        prev_ov   = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;

        tbl[0] = tv(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        tbl[1] = tv(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        tbl[2] = tv(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        tbl[3] = tv(64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
        tbl[4] = tv(64'd7, 64'd7, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1);
        tbl[5] = tv(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
        tbl[6] = tv(64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0, 1'b0);
        tbl[7] = tv(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
                    64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b0);

        #12;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_sum",       out_sum,        64'd0);
        chk("rst_cout",      64'(out_cout),  64'd0);
        chk("rst_ovf",       64'(out_ovf),   64'd0);
        chk("rst_zero",      64'(out_zero),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        prev_acc = 0;
        for (int i = 0; i < 8; i++) begin
            send(tbl[i]);
            if (i > 0) chk("throughput", 64'(acc_cyc - prev_acc), 64'(N + 2));
            prev_acc = acc_cyc;
        end
        for (int i = 0; i < 12; i++) begin
            send(mk({$urandom(), $urandom()}, {$urandom(), $urandom()},
                    1'($urandom()), 1'($urandom())));
        end
        drain();

        // Backpressure: result must hold while a new request waits.
        vx = tbl[7];
        vy = tbl[4];
        out_ready = 1'b0;
        send(vx);
        in_a     = vy.a;
        in_b     = vy.b;
        in_cin   = vy.cin;
        in_sub   = vy.sub;
        in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 20);
        chk("bp_valid_wait", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid",    64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready),  64'd0);
            chk("bp_sum",      out_sum,        vx.sum);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rel = cyc;
        send(vy);
        chk("bp_accept_delay", 64'(acc_cyc - rel), 64'd2);
        chk("bp_busy_run",     64'(busy),          64'd1);
        drain();

        // Reset two cycles into a transaction aborts it.
        send(tbl[7]);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ab_out_valid", 64'(out_valid), 64'd0);
        chk("ab_in_ready",  64'(in_ready),  64'd1);
        chk("ab_busy",      64'(busy),      64'd0);
        chk("ab_sum",       out_sum,        64'd0);
        chk("ab_cout",      64'(out_cout),  64'd0);
        chk("ab_zero",      64'(out_zero),  64'd0);
        chk("ab_ovf",       64'(out_ovf),   64'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_in_ready",  64'(in_ready),  64'd1);
            chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(tbl[5]);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
